// File: rtl/gray_sync_decoder_if.sv
// gray_sync_decoder_if: gray input, error clear and decoded count outputs
interface gray_sync_decoder_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] gray_in;
  logic             clr_err;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] delta;
  logic             upd;
  logic             err;
  modport master (output gray_in, clr_err, input bin_out, delta, upd, err);
  modport slave  (input gray_in, clr_err, output bin_out, delta, upd, err);
endinterface

// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder: synchronizes a remote gray count, decodes it and reports increments; GRAY_CHECK_EN adds a sticky multi-bit-step error
module gray_sync_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  gray_sync_decoder_if.slave bus
);
  typedef enum logic [1:0] {FILL, PRIME, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] g_sync, dec;
  logic [WIDTH-1:0] g_prev_q, g_prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             upd_q, upd_d;
  logic [2:0]       fill_q, fill_d;
  logic             changed;
  assign g_sync  = sync_q[SYNC_STAGES-1];
  assign changed = g_sync != g_prev_q;
  // each binary bit is the parity of the gray bits at and above it
  always_comb
    for (int i = 0; i < WIDTH; i++) dec[i] = ^(g_sync >> i);
  // synchronizer chain shifting the raw gray word toward g_sync
  always_comb begin
    sync_d[0] = bus.gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  // control: wait for the chain to fill, prime the baseline, then track changes
  always_comb begin
    state_d  = state_q == FILL ? (fill_q == 3'(SYNC_STAGES-1) ? PRIME : FILL) : RUN;
    fill_d   = state_q == FILL ? fill_q + 3'd1 : fill_q;
    g_prev_d = g_sync;
    upd_d    = state_q == RUN && changed;
    bin_d    = (state_q == PRIME || upd_d) ? dec : bin_q;
    delta_d  = upd_d ? dec - bin_q : delta_q;
  end
  // state registers; reset abandons anything in flight and restarts the fill
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= FILL;
      sync_q   <= '{default: '0};
      g_prev_q <= '0;
      bin_q    <= '0;
      delta_q  <= '0;
      upd_q    <= 1'b0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      g_prev_q <= g_prev_d;
      bin_q    <= bin_d;
      delta_q  <= delta_d;
      upd_q    <= upd_d;
      fill_q   <= fill_d;
    end
  assign bus.bin_out = bin_q;
  assign bus.delta   = delta_q;
  assign bus.upd     = upd_q;
`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] diff;
  logic             err_q, err_d;
  // more than one bit flipped means the source broke the gray rule; set beats clear
  always_comb begin
    diff  = g_sync ^ g_prev_q;
    err_d = (state_q == RUN && |(diff & (diff - WIDTH'(1)))) || (err_q && !bus.clr_err);
  end
  // sticky error flag
  always_ff @(posedge clk)
    err_q <= rst ? 1'b0 : err_d;
  assign bus.err = err_q;
`else
  logic unused_clr;
  assign unused_clr = bus.clr_err;
  assign bus.err    = 1'b0;
`endif
endmodule

// File: doc/gray_sync_decoder.md
GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 Parameter WIDTH, default 8, is the gray/binary word width (legal 2..32).
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth in flops (legal 2..4).
REQ-003 clk  input  1  sampling clock, asynchronous to the gray_in source.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 gray_in  input  WIDTH  gray-coded count from a remote counter; changes at most one bit per source step.
REQ-006 clr_err  input  1  clears sticky err; level-sensitive, sampled on clk.
REQ-007 bin_out  output  WIDTH  registered binary decode of the synchronized gray word.
REQ-008 delta  output  WIDTH  registered binary increment since the previous bin_out, modulo 2^WIDTH.
REQ-009 upd  output  1  one-cycle pulse when bin_out takes a new value.
REQ-010 err  output  1  sticky flag for a multi-bit gray transition; constant 0 when GRAY_CHECK_EN is undefined.

Function
REQ-011 gray_in SHALL pass through a SYNC_STAGES-deep flop chain; its last stage is g_sync.
REQ-012 Decode SHALL be b[WIDTH-1]=g[WIDTH-1], b[i]=b[i+1] XOR g[i] for i=WIDTH-2..0.
REQ-013 A register g_prev SHALL hold the g_sync value of the previous clock.
REQ-014 Control FSM states: FILL, PRIME, RUN.
REQ-015 FILL: a fill counter counts SYNC_STAGES clocks after reset; upd=0; bin_out and delta hold 0; FSM then goes to PRIME.
REQ-016 PRIME (one cycle): bin_out loads decode(g_sync); g_prev loads g_sync; delta stays 0; upd stays 0; no error check; FSM then goes to RUN.
REQ-017 RUN, g_sync != g_prev: next edge loads bin_out=decode(g_sync), delta=decode(g_sync)-bin_out (mod 2^WIDTH), and upd=1 for exactly one cycle.
REQ-018 RUN, g_sync == g_prev: bin_out and delta hold; upd=0.
REQ-019 Latency SHALL be SYNC_STAGES+1 clk edges from a gray_in change meeting setup to the bin_out/upd update.
REQ-020 Wrap-around: binary 2^WIDTH-1 -> 0 (gray 0x80 -> 0x00 at WIDTH=8) SHALL give delta=1, with no err.
REQ-021 Back-to-back source steps on consecutive clocks SHALL give consecutive upd pulses, each delta=1.
REQ-022 Backward step (source decrement) SHALL give delta = 2^WIDTH-1; no special handling.

Reset
REQ-023 On rst=1 at a clk edge, all sync flops, g_prev, bin_out, delta, upd, err and the fill counter SHALL go to 0, and the FSM SHALL go to FILL.
REQ-024 rst asserted mid-RUN SHALL abandon any in-flight update; the PRIME sequence SHALL repeat after release.
REQ-025 rst SHALL take priority over clr_err and over error detection.

Configuration
REQ-026 Macro GRAY_CHECK_EN defined: in RUN, popcount(g_sync XOR g_prev) > 1 SHALL set err on the next edge; err then stays 1 until clr_err or rst.
REQ-027 With GRAY_CHECK_EN defined, simultaneous err-set and clr_err SHALL leave err=1 (set wins); a multi-bit transition SHALL still update bin_out, delta and upd normally.
REQ-028 GRAY_CHECK_EN undefined: no check logic; err tied to 0; clr_err ignored.

Verification
REQ-029 Reset while gray_in=0x35 (binary 0x26), hold 4 clocks: upd never pulses; bin_out=0x26 and delta=0 after FILL+PRIME.
REQ-030 Step gray_in 0x00->0x01->0x03->0x02 one step per 3 clocks: three upd pulses; bin_out=1,2,3; delta=1 each; latency 3 edges at SYNC_STAGES=2.
REQ-031 Step binary 0xFF->0x00 (gray 0x80->0x00): one upd; bin_out=0x00; delta=0x01; err=0.
REQ-032 GRAY_CHECK_EN defined, in RUN jump gray_in 0x01->0x06: err=1 and stays 1; bin_out=0x04; delta=0x03; clr_err pulse -> err=0; clr_err concurrent with a new error -> err=1.
REQ-033 Assert rst mid-sequence with a change in the sync chain: no upd is emitted; all outputs are 0 next cycle; FSM re-primes to the current gray_in.
REQ-034 Source steps on every clk for 300 cycles from 0: 300 upd pulses, each delta=1, one wrap; final bin_out=0x2C; err=0.
